// File: rtl/ic_bus_pkg.sv
// Shared bus constants: transaction type tags for the order FIFO and AXI response codes.
package ic_bus_pkg;

  typedef logic txn_t;

  localparam txn_t TXN_RD = 1'b0;
  localparam txn_t TXN_WR = 1'b1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/ic_cpu_bus_axi_bridge_ot_if.sv
// AXI4-Lite bus between the bridge (master) and the interconnect (slave).
interface ic_cpu_bus_axi_bridge_ot_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              rvalid, rready;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rresp, rdata, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rresp, rdata, input rready
  );

endinterface

// File: rtl/ic_bridge_order_fifo.sv
// Small circular FIFO recording the type of each accepted request so that
// responses are returned to the CPU in request order.
module ic_bridge_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             m0_aclk,
  input  logic             m0_areset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; an entry is only read after it was written, and empty gates its use.
  always_ff @(posedge m0_aclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge m0_aclk or posedge m0_areset) begin
    if (m0_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ic_cpu_bus_axi_bridge_ot.sv
// CPU req/gnt + recv/ack port to AXI4-Lite master bridge with up to MAX_OT
// outstanding requests; responses are returned strictly in request order.
module ic_cpu_bus_axi_bridge_ot
  import ic_bus_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter int         MAX_OT = 4,
  parameter logic [2:0] AXPROT = 3'b000
) (
  input  logic                  m0_aclk,
  input  logic                  m0_areset,
  ic_cpu_bus_axi_bridge_ot_if.master m0,
  input  logic                  enable,
  input  logic                  mem_req,
  output logic                  mem_gnt,
  input  logic                  mem_wen,
  input  logic [DATA_W/8-1:0]   mem_strb,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_recv,
  input  logic                  mem_ack,
  output logic                  mem_error,
  output logic [DATA_W-1:0]     mem_rdata
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_OT + 1);

  logic [CNT_W-1:0]  ot_cnt;
  logic              aw_pend, w_pend, ar_pend;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              accept, pop;
  logic              fifo_full, fifo_empty;
  txn_t              head;
  logic              head_rd;

  // Grant is held low during reset and never looks at any AXI ready.
  assign mem_gnt = !m0_areset && enable && (ot_cnt < CNT_W'(MAX_OT)) &&
                   (mem_wen ? (!aw_pend && !w_pend) : !ar_pend);
  assign accept  = mem_req && mem_gnt;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge m0_aclk or posedge m0_areset) begin
    if (m0_areset) begin
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
      ar_pend   <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (accept && mem_wen) begin
        aw_pend   <= 1'b1;
        w_pend    <= 1'b1;
        aw_addr_q <= mem_addr;
        wdata_q   <= mem_wdata;
        wstrb_q   <= mem_strb;
      end else begin
        if (aw_pend && m0.awready) aw_pend <= 1'b0;
        if (w_pend && m0.wready)   w_pend  <= 1'b0;
      end
      if (accept && !mem_wen) begin
        ar_pend   <= 1'b1;
        ar_addr_q <= mem_addr;
      end else if (ar_pend && m0.arready) begin
        ar_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge m0_aclk or posedge m0_areset) begin
    if (m0_areset)          ot_cnt <= '0;
    else if (accept && !pop) ot_cnt <= ot_cnt + CNT_W'(1);
    else if (!accept && pop) ot_cnt <= ot_cnt - CNT_W'(1);
  end

  assign m0.awvalid = aw_pend;
  assign m0.awaddr  = aw_addr_q;
  assign m0.awprot  = AXPROT;
  assign m0.wvalid  = w_pend;
  assign m0.wdata   = wdata_q;
  assign m0.wstrb   = wstrb_q;
  assign m0.arvalid = ar_pend;
  assign m0.araddr  = ar_addr_q;
  assign m0.arprot  = AXPROT;

  ic_bridge_order_fifo #(
    .DEPTH (MAX_OT),
    .WIDTH (1)
  ) u_order_fifo (
    .m0_aclk   (m0_aclk),
    .m0_areset (m0_areset),
    .push      (accept),
    .push_data (mem_wen ? TXN_WR : TXN_RD),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Only the response type at the FIFO head is readied; the other channel waits.
  assign head_rd   = !fifo_empty && (head == TXN_RD);
  assign mem_recv  = !fifo_empty && (head_rd ? m0.rvalid : m0.bvalid);
  assign m0.rready = head_rd && mem_ack;
  assign m0.bready = !fifo_empty && (head == TXN_WR) && mem_ack;
  assign mem_error = mem_recv && (head_rd ? |m0.rresp : |m0.bresp);
  assign mem_rdata = (mem_recv && head_rd) ? m0.rdata : '0;
  assign pop       = mem_recv && mem_ack;

  a_no_push_when_full: assert property (
    @(posedge m0_aclk) disable iff (m0_areset) !(accept && fifo_full));

endmodule

// File: tb/tb_ic_cpu_bus_axi_bridge_ot.sv
// Directed bench for the CPU-bus to AXI4-Lite bridge: reset, reads, writes,
// outstanding limit, response ordering and error mapping.
module tb_ic_cpu_bus_axi_bridge_ot;

  logic        m0_aclk;
  logic        m0_areset;
  logic        enable, mem_req, mem_wen, mem_ack;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr;
  logic        mem_gnt, mem_recv, mem_error;
  logic [31:0] mem_rdata;

  int tests_run;
  int tests_failed;

  ic_cpu_bus_axi_bridge_ot_if #(.ADDR_W(32), .DATA_W(32)) m0 ();

  ic_cpu_bus_axi_bridge_ot #(
    .ADDR_W(32), .DATA_W(32), .MAX_OT(4), .AXPROT(3'b000)
  ) dut (
    .m0_aclk   (m0_aclk),
    .m0_areset (m0_areset),
    .m0        (m0),
    .enable    (enable),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata)
  );

  initial m0_aclk = 1'b0;
  always #5 m0_aclk = ~m0_aclk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge m0_aclk);
  endtask

  task automatic test_reset();
    #1;
    if (m0.arvalid !== 1'b0) begin $display("FAIL rst_arvalid: got %b want 0", m0.arvalid); tests_failed++; end tests_run++;
    if (m0.awvalid !== 1'b0 || m0.wvalid !== 1'b0) begin $display("FAIL rst_aw_w_valid: got %b%b want 00", m0.awvalid, m0.wvalid); tests_failed++; end tests_run++;
    if (m0.rready !== 1'b0 || m0.bready !== 1'b0) begin $display("FAIL rst_readies: got %b%b want 00", m0.rready, m0.bready); tests_failed++; end tests_run++;
    if (mem_gnt !== 1'b0) begin $display("FAIL rst_gnt: got %b want 0", mem_gnt); tests_failed++; end tests_run++;
    if (mem_recv !== 1'b0 || mem_error !== 1'b0 || mem_rdata !== 32'h0) begin
      $display("FAIL rst_resp: got recv=%b err=%b rdata=%h want 0 0 0", mem_recv, mem_error, mem_rdata); tests_failed++; end tests_run++;
    step();
    m0_areset = 1'b0;
    #1;
    if (mem_gnt !== 1'b1) begin $display("FAIL rst_release_gnt: got %b want 1", mem_gnt); tests_failed++; end tests_run++;
    step();
  endtask

  task automatic test_single_read();
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_1000;
    #1;
    if (mem_gnt !== 1'b1) begin $display("FAIL rd_gnt: got %b want 1", mem_gnt); tests_failed++; end tests_run++;
    step();
    mem_req = 1'b0;
    #1;
    if (m0.arvalid !== 1'b1 || m0.araddr !== 32'h0000_1000 || m0.arprot !== 3'b000) begin
      $display("FAIL rd_ar: got v=%b a=%h p=%b want 1 00001000 000", m0.arvalid, m0.araddr, m0.arprot); tests_failed++; end tests_run++;
    m0.arready = 1'b1;
    step();
    m0.arready = 1'b0;
    #1;
    if (m0.arvalid !== 1'b0) begin $display("FAIL rd_ar_clear: got %b want 0", m0.arvalid); tests_failed++; end tests_run++;
    step();
    m0.rvalid = 1'b1; m0.rdata = 32'hCAFE_F00D; m0.rresp = 2'b00; mem_ack = 1'b1;
    #1;
    if (mem_recv !== 1'b1 || mem_rdata !== 32'hCAFE_F00D || mem_error !== 1'b0 || m0.rready !== 1'b1) begin
      $display("FAIL rd_resp: got recv=%b rdata=%h err=%b rready=%b want 1 cafef00d 0 1", mem_recv, mem_rdata, mem_error, m0.rready);
      tests_failed++; end tests_run++;
    step();
    m0.rvalid = 1'b0; mem_ack = 1'b0;
    #1;
    if (mem_recv !== 1'b0) begin $display("FAIL rd_recv_drop: got %b want 0", mem_recv); tests_failed++; end tests_run++;
    step();
  endtask

  task automatic test_max_ot();
    int n_gnt;
    n_gnt = 0;
    mem_req = 1'b1; mem_wen = 1'b0; m0.arready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      mem_addr = 32'h0000_2000 + 32'(c * 4);
      #1;
      if (mem_gnt === 1'b1) n_gnt++;
      step();
    end
    if (n_gnt !== 4) begin $display("FAIL ot_gnt_count: got %0d want 4", n_gnt); tests_failed++; end tests_run++;
    #1;
    if (mem_gnt !== 1'b0) begin $display("FAIL ot_fifth_blocked: got %b want 0", mem_gnt); tests_failed++; end tests_run++;
    m0.rvalid = 1'b1; m0.rresp = 2'b00; m0.rdata = 32'h1111_1111; mem_ack = 1'b1;
    #1;
    if (mem_recv !== 1'b1 || mem_gnt !== 1'b0) begin
      $display("FAIL ot_first_resp: got recv=%b gnt=%b want 1 0", mem_recv, mem_gnt); tests_failed++; end tests_run++;
    step();
    #1;
    if (mem_gnt !== 1'b1) begin $display("FAIL ot_gnt_after_resp: got %b want 1", mem_gnt); tests_failed++; end tests_run++;
    step();
    mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_recv !== 1'b1) begin $display("FAIL ot_drain_%0d: got %b want 1", i, mem_recv); tests_failed++; end tests_run++;
      step();
    end
    #1;
    if (mem_recv !== 1'b0) begin $display("FAIL ot_empty: got %b want 0", mem_recv); tests_failed++; end tests_run++;
    m0.rvalid = 1'b0; mem_ack = 1'b0; m0.arready = 1'b0;
    step();
  endtask

  task automatic test_write_split();
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h0000_3000;
    mem_wdata = 32'hDEAD_BEEF; mem_strb = 4'b0110;
    #1;
    if (mem_gnt !== 1'b1) begin $display("FAIL wr_gnt: got %b want 1", mem_gnt); tests_failed++; end tests_run++;
    step();
    mem_req = 1'b0; m0.wready = 1'b1;
    #1;
    if (m0.awvalid !== 1'b1 || m0.wvalid !== 1'b1 || m0.awaddr !== 32'h0000_3000 ||
        m0.wdata !== 32'hDEAD_BEEF || m0.wstrb !== 4'b0110 || m0.awprot !== 3'b000) begin
      $display("FAIL wr_issue: got aw=%b w=%b a=%h d=%h s=%b want 1 1 00003000 deadbeef 0110",
               m0.awvalid, m0.wvalid, m0.awaddr, m0.wdata, m0.wstrb); tests_failed++; end tests_run++;
    step();
    m0.wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) m0.awready = 1'b1;
      #1;
      if (m0.wvalid !== 1'b0 || m0.awvalid !== 1'b1 || m0.awaddr !== 32'h0000_3000 || mem_gnt !== 1'b0) begin
        $display("FAIL wr_aw_hold_%0d: got w=%b aw=%b a=%h gnt=%b want 0 1 00003000 0", i, m0.wvalid, m0.awvalid, m0.awaddr, mem_gnt);
        tests_failed++; end tests_run++;
      step();
    end
    m0.awready = 1'b0;
    #1;
    if (m0.awvalid !== 1'b0 || mem_gnt !== 1'b1) begin
      $display("FAIL wr_aw_done: got aw=%b gnt=%b want 0 1", m0.awvalid, mem_gnt); tests_failed++; end tests_run++;
    m0.bvalid = 1'b1; m0.bresp = 2'b00; mem_ack = 1'b1;
    #1;
    if (mem_recv !== 1'b1 || mem_error !== 1'b0 || m0.bready !== 1'b1 || mem_rdata !== 32'h0) begin
      $display("FAIL wr_resp: got recv=%b err=%b bready=%b rdata=%h want 1 0 1 0", mem_recv, mem_error, m0.bready, mem_rdata);
      tests_failed++; end tests_run++;
    step();
    m0.bvalid = 1'b0; mem_ack = 1'b0;
    #1;
    if (mem_recv !== 1'b0) begin $display("FAIL wr_single_recv: got %b want 0", mem_recv); tests_failed++; end tests_run++;
    step();
  endtask

  task automatic test_order();
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_4000;
    step();
    mem_wen = 1'b1; mem_addr = 32'h0000_5000; mem_wdata = 32'h0BAD_F00D; mem_strb = 4'hF;
    m0.arready = 1'b1;
    step();
    mem_req = 1'b0; m0.arready = 1'b0; m0.awready = 1'b1; m0.wready = 1'b1;
    step();
    m0.awready = 1'b0; m0.wready = 1'b0;
    m0.bvalid = 1'b1; m0.bresp = 2'b00; mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (mem_recv !== 1'b0 || m0.bready !== 1'b0) begin
        $display("FAIL ord_b_wait_%0d: got recv=%b bready=%b want 0 0", i, mem_recv, m0.bready); tests_failed++; end tests_run++;
      step();
    end
    m0.rvalid = 1'b1; m0.rresp = 2'b00; m0.rdata = 32'h1234_5678;
    #1;
    if (mem_recv !== 1'b1 || m0.rready !== 1'b1 || m0.bready !== 1'b0 || mem_rdata !== 32'h1234_5678) begin
      $display("FAIL ord_rd_first: got recv=%b rready=%b bready=%b rdata=%h want 1 1 0 12345678",
               mem_recv, m0.rready, m0.bready, mem_rdata); tests_failed++; end tests_run++;
    step();
    m0.rvalid = 1'b0;
    #1;
    if (mem_recv !== 1'b1 || m0.bready !== 1'b1 || m0.rready !== 1'b0 || mem_rdata !== 32'h0) begin
      $display("FAIL ord_wr_second: got recv=%b bready=%b rready=%b rdata=%h want 1 1 0 0",
               mem_recv, m0.bready, m0.rready, mem_rdata); tests_failed++; end tests_run++;
    step();
    m0.bvalid = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_errors();
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h0000_6000; mem_wdata = 32'h0; mem_strb = 4'hF;
    step();
    mem_req = 1'b0; m0.awready = 1'b1; m0.wready = 1'b1;
    step();
    m0.awready = 1'b0; m0.wready = 1'b0;
    m0.bvalid = 1'b1; m0.bresp = 2'b10; mem_ack = 1'b1;
    #1;
    if (mem_recv !== 1'b1 || mem_error !== 1'b1) begin
      $display("FAIL bresp_slverr: got recv=%b err=%b want 1 1", mem_recv, mem_error); tests_failed++; end tests_run++;
    step();
    m0.bvalid = 1'b0; m0.bresp = 2'b00; mem_ack = 1'b0;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_7000;
    step();
    mem_req = 1'b0; m0.arready = 1'b1;
    step();
    m0.arready = 1'b0;
    m0.rvalid = 1'b1; m0.rresp = 2'b11; m0.rdata = 32'hA5A5_5A5A; mem_ack = 1'b1;
    #1;
    if (mem_recv !== 1'b1 || mem_error !== 1'b1 || mem_rdata !== 32'hA5A5_5A5A) begin
      $display("FAIL rresp_decerr: got recv=%b err=%b rdata=%h want 1 1 a5a55a5a", mem_recv, mem_error, mem_rdata);
      tests_failed++; end tests_run++;
    step();
    m0.rvalid = 1'b0; m0.rresp = 2'b00; mem_ack = 1'b0;
    step();
  endtask

  task automatic test_enable();
    enable = 1'b0; mem_req = 1'b1; mem_wen = 1'b0;
    #1;
    if (mem_gnt !== 1'b0) begin $display("FAIL enable_low_gnt: got %b want 0", mem_gnt); tests_failed++; end tests_run++;
    step();
    enable = 1'b1; mem_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_8000;
    step();
    mem_wen = 1'b1; mem_addr = 32'h0000_9000;
    step();
    mem_req = 1'b0;
    #1;
    if (m0.arvalid !== 1'b1 || m0.awvalid !== 1'b1 || m0.wvalid !== 1'b1) begin
      $display("FAIL mid_pending: got ar=%b aw=%b w=%b want 1 1 1", m0.arvalid, m0.awvalid, m0.wvalid); tests_failed++; end tests_run++;
    #1;
    m0_areset = 1'b1;
    #1;
    if (m0.arvalid !== 1'b0 || m0.awvalid !== 1'b0 || m0.wvalid !== 1'b0 || mem_gnt !== 1'b0) begin
      $display("FAIL mid_async_clear: got ar=%b aw=%b w=%b gnt=%b want 0 0 0 0", m0.arvalid, m0.awvalid, m0.wvalid, mem_gnt);
      tests_failed++; end tests_run++;
    step();
    m0_areset = 1'b0; mem_wen = 1'b0; m0.rvalid = 1'b1; m0.bvalid = 1'b1; mem_ack = 1'b1;
    #1;
    if (mem_gnt !== 1'b1 || mem_recv !== 1'b0 || m0.rready !== 1'b0 || m0.bready !== 1'b0) begin
      $display("FAIL mid_release: got gnt=%b recv=%b rready=%b bready=%b want 1 0 0 0", mem_gnt, mem_recv, m0.rready, m0.bready);
      tests_failed++; end tests_run++;
    m0.rvalid = 1'b0; m0.bvalid = 1'b0; mem_ack = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    m0_areset = 1'b1;
    enable = 1'b1; mem_req = 1'b0; mem_wen = 1'b0; mem_ack = 1'b0;
    mem_strb = '0; mem_wdata = '0; mem_addr = '0;
    m0.awready = 1'b0; m0.wready = 1'b0; m0.arready = 1'b0;
    m0.bvalid = 1'b0; m0.bresp = 2'b00;
    m0.rvalid = 1'b0; m0.rresp = 2'b00; m0.rdata = '0;

    test_reset();
    test_single_read();
    test_max_ot();
    test_write_split();
    test_order();
    test_errors();
    test_enable();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
